// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the multi-channel tick generator.
package tick_gen_pkg;

  localparam int DEF_DIV_W       = 16;
  localparam int DEF_DIV_DEFAULT = 25;
  localparam int MAX_CH          = 16;

  typedef logic [DEF_DIV_W-1:0]       div_t;
  typedef logic [$clog2(MAX_CH)-1:0]  ch_idx_t;

  typedef enum logic [1:0] {PH_0, PH_1, PH_2, PH_3} phase_t;

  // Quadrature phase advance, wrapping PH_3 back to PH_0.
  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_0:    n = PH_1;
      PH_1:    n = PH_2;
      PH_2:    n = PH_3;
      default: n = PH_0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One strobe channel: divisor/quad registers, terminal-count counter,
// quadrature phase and the glitch-free config apply point.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DIV_DEFAULT = DEF_DIV_DEFAULT
) (
  input  logic             clk_10MHz,
  input  logic             areset_n,
  input  logic             en,
  input  logic             restart,
  input  logic             apply_req,
  input  logic [DIV_W-1:0] new_div,
  input  logic             new_quad,
  output logic             strobe,
  output logic [1:0]       phase,
  output logic             apply_done
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] deff;
  logic             quad_q;
  logic             strobe_q;
  phase_t           ph_q;
  logic             tc;
  logic             quad_chg;

  // Divisors of 0 and 1 both mean "strobe every cycle".
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d > ONE) ? d : ONE;
  endfunction

  assign deff = eff_div(div_q);
  assign tc   = (cnt_q == deff - ONE);

  // A pending config lands only at a period boundary: terminal count,
  // while the channel is idle, or on a global realign.
  assign apply_done = apply_req && (restart || !en || tc);
  assign quad_chg   = apply_done && (new_quad != quad_q);

  // Counter, strobe, phase and configuration registers.
  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      div_q    <= DIV_W'(DIV_DEFAULT);
      quad_q   <= 1'b0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      ph_q     <= PH_0;
    end else begin
      if (restart) begin
        cnt_q    <= '0;
        strobe_q <= 1'b0;
        ph_q     <= PH_0;
      end else if (!en) begin
        cnt_q    <= '0;
        strobe_q <= 1'b0;
        if (quad_chg) ph_q <= PH_0;
      end else if (tc) begin
        cnt_q    <= '0;
        strobe_q <= 1'b1;
        if (quad_chg)    ph_q <= PH_0;
        else if (quad_q) ph_q <= next_phase(ph_q);
      end else begin
        cnt_q    <= cnt_q + ONE;
        strobe_q <= 1'b0;
      end
      if (apply_done) begin
        div_q  <= new_div;
        quad_q <= new_quad;
      end
    end
  end

  assign strobe = strobe_q;
  assign phase  = ph_q;

endmodule

// File: rtl/tick_gen_mc.sv
// Multi-channel programmable strobe generator: NUM_CH channels sharing a
// single-entry config slot, plus the free-running heartbeat counter.
module tick_gen_mc
  import tick_gen_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = DEF_DIV_W,
  parameter  int DIV_DEFAULT = DEF_DIV_DEFAULT,
  parameter  int HB_W        = 24,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_10MHz,
  input  logic                areset_n,
  input  logic [NUM_CH-1:0]   en,
  input  logic                sync_restart,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cfg_quad,
  output logic                cfg_ready,
  output logic                cfg_ack,
  output logic [NUM_CH-1:0]   strobe,
  output logic [2*NUM_CH-1:0] phase,
  output logic                heartbeat
);

  logic [CH_W-1:0]   slot_ch;
  logic [DIV_W-1:0]  slot_div;
  logic              slot_quad;
  logic              slot_vld;
  logic              slot_bad;
  logic              slot_done;
  logic [NUM_CH-1:0] apply_req;
  logic [NUM_CH-1:0] apply_done;
  logic [HB_W-1:0]   hb_cnt;

  // The slot is occupied exactly while cfg_ready is low.
  assign slot_vld  = !cfg_ready;
  assign slot_bad  = slot_vld && (32'(slot_ch) >= NUM_CH);
  assign slot_done = (|apply_done) || slot_bad;

  // Slot payload is only consulted while occupied, so it needs no reset.
  always_ff @(posedge clk_10MHz) begin
    if (cfg_ready && cfg_wr) begin
      slot_ch   <= cfg_ch;
      slot_div  <= cfg_div;
      slot_quad <= cfg_quad;
    end
  end

  // Slot occupancy and the one-cycle acknowledge.
  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      cfg_ready <= 1'b1;
      cfg_ack   <= 1'b0;
    end else begin
      cfg_ack <= slot_done;
      if (cfg_ready && cfg_wr) cfg_ready <= 1'b0;
      else if (slot_done)      cfg_ready <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign apply_req[c] = slot_vld && (32'(slot_ch) == c);

    tick_gen_ch #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ch (
      .clk_10MHz  (clk_10MHz),
      .areset_n   (areset_n),
      .en         (en[c]),
      .restart    (sync_restart),
      .apply_req  (apply_req[c]),
      .new_div    (slot_div),
      .new_quad   (slot_quad),
      .strobe     (strobe[c]),
      .phase      (phase[2*c+1:2*c]),
      .apply_done (apply_done[c])
    );
  end

  // Free-running heartbeat counter; its MSB drives the LED.
  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) hb_cnt <= '0;
    else           hb_cnt <= hb_cnt + 1'b1;
  end

  assign heartbeat = hb_cnt[HB_W-1];

endmodule
